img_row_packer: RTL and testbench

Upstream feeder for the 512×640 coprocessor image buffer. Accepts a valid/ready stream of 8-bit grayscale pixels and packs 80 consecutive pixels into one 640-bit row word. It writes each completed word into the buffer's write port at sequential addresses, one frame at a time. Once started, it sustains one pixel per cycle with no bubbles and signals frame completion to the coprocessor controller.

---
 rtl/img_row_packer.sv | 164 ++++++++++++++++
 tb/tb_img_row_packer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/img_row_packer.sv
// -----------------------------------------------------------------------------
// img_row_packer
//
// Packs a valid/ready stream of grayscale pixels into row words for the
// coprocessor image buffer. PIX_PER_WORD consecutive pixels form one word,
// with pixel 0 in the least significant byte. Completed words are written at
// sequential addresses 0..FRAME_WORDS-1, one frame per start pulse. The packer
// accepts one pixel per cycle with no bubbles. It raises frame_done with the
// final write of a frame.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         asynchronous active-high reset
//   start       single-cycle pulse, arms a new frame (ignored while busy)
//   pix_in      pixel data
//   pix_vld     pix_in valid
//   pix_rdy     packer can accept (handshake = pix_vld & pix_rdy)
//   we          buffer write enable (registered)
//   waddr       buffer write address (registered, held while we=0)
//   wdata       buffer write data (registered, held while we=0)
//   busy        high from start accept until frame done
//   frame_done  single-cycle pulse coinciding with the last write of a frame
// -----------------------------------------------------------------------------
module img_row_packer #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 80,
    parameter int FRAME_WORDS  = 512
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [PIX_W-1:0]                    pix_in,
    input  logic                                pix_vld,
    output logic                                pix_rdy,
    output logic                                we,
    output logic [$clog2(FRAME_WORDS)-1:0]      waddr,
    output logic [PIX_W*PIX_PER_WORD-1:0]       wdata,
    output logic                                busy,
    output logic                                frame_done
);

    localparam int WORD_W = PIX_W * PIX_PER_WORD;
    localparam int PCNT_W = $clog2(PIX_PER_WORD);
    localparam int ADDR_W = $clog2(FRAME_WORDS);
    // One extra bit so the word counter can represent FRAME_WORDS itself
    // after the final increment without aliasing back to address 0.
    localparam int WCNT_W = ADDR_W + 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PIX_PER_WORD - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_WORDS - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PCNT_W-1:0]   r_pcnt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WORD_W-1:0]   r_asm;

    logic                w_start_acc;
    logic                w_hs;
    logic                w_word_end;
    logic                w_frame_end;

    // -------------------------------------------------------------------------
    // Next-state and handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        pix_rdy     = 1'b0;
        busy        = 1'b0;
        w_start_acc = 1'b0;
        w_hs        = 1'b0;
        w_word_end  = 1'b0;
        w_frame_end = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                pix_rdy     = 1'b1;
                busy        = 1'b1;
                w_hs        = pix_vld;
                w_word_end  = w_hs && (r_pcnt == PCNT_LAST);
                w_frame_end = w_word_end && (r_wcnt == WCNT_LAST);
                if (w_frame_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments in clocked blocks, so every
            // register samples pre-edge values regardless of statement order.
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Counters and registered write port
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt     <= '0;
            r_wcnt     <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            frame_done <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            if (w_start_acc) begin
                r_pcnt <= '0;
                r_wcnt <= '0;
            end else if (w_hs) begin
                if (w_word_end) begin
                    // The last pixel bypasses the assembly register so the
                    // word is written on the same edge that accepts it.
                    wdata      <= {pix_in, r_asm[WORD_W-PIX_W-1:0]};
                    waddr      <= r_wcnt[ADDR_W-1:0];
                    we         <= 1'b1;
                    frame_done <= w_frame_end;
                    r_pcnt     <= '0;
                    r_wcnt     <= r_wcnt + WCNT_W'(1);
                end else begin
                    r_pcnt     <= r_pcnt + PCNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Assembly register
    // -------------------------------------------------------------------------
    // NOTE: pure datapath storage is left without reset. Every byte is
    // rewritten before the word is emitted, so its power-up contents never
    // reach wdata.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_asm[PIX_W*r_pcnt +: PIX_W] <= pix_in;
        end
    end

endmodule

// File: tb/tb_img_row_packer.sv
// -----------------------------------------------------------------------------
// tb_img_row_packer
//
// Directed sequence with randomized data and valid gaps. Expected words are
// built from the pixel array of the current frame. Word k is pixels
// 80k..80k+79, with pixel j of the word in byte j.
// -----------------------------------------------------------------------------
module tb_img_row_packer;

    localparam int PIX_W = 8;
    localparam int PPW   = 80;
    localparam int FW    = 512;
    localparam int NPIX  = PPW * FW;
    localparam int WW    = PIX_W * PPW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [7:0]      pix_in;
    logic            pix_vld;
    logic            pix_rdy;
    logic            we;
    logic [8:0]      waddr;
    logic [WW-1:0]   wdata;
    logic            busy;
    logic            frame_done;

    int total = 0;
    int bad   = 0;

    logic [7:0] pix_mem [NPIX];

    always #5 clk = ~clk;

    img_row_packer #(
        .PIX_W        (PIX_W),
        .PIX_PER_WORD (PPW),
        .FRAME_WORDS  (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_in     (pix_in),
        .pix_vld    (pix_vld),
        .pix_rdy    (pix_rdy),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .frame_done (frame_done)
    );

    function automatic logic [WW-1:0] model_word(input int k);
        logic [WW-1:0] w;
        w = '0;
        for (int j = 0; j < PPW; j++) begin
            w[PIX_W*j +: PIX_W] = pix_mem[k*PPW + j];
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Streams one frame after the packer has been started. Pixels are drawn
    // from pix_mem. In gap mode, pix_vld is random at 50% for the first ten
    // and last four words and continuous elsewhere. Handshakes are counted
    // from what the bench drives, because pix_rdy must be high for the whole
    // frame.
    task automatic run_frame(input bit gaps, input bit poke_start, input bit first_word_checks);
        int idx     = 0;
        int nwr     = 0;
        int cyc     = 0;
        int last_we = 0;
        int wk;
        bit vld;
        bit exp_we;
        while (nwr < FW && cyc < 60000) begin
            wk  = idx / PPW;
            vld = 1'b1;
            if (gaps && (wk < 10 || wk >= FW - 4)) begin
                vld = ($urandom_range(0, 1) == 1);
            end
            pix_vld = vld;
            pix_in  = (vld && idx < NPIX) ? pix_mem[idx] : 8'($urandom);
            start   = poke_start && ((cyc % 997) == 5);
            chk("pix_rdy_fill", pix_rdy, 1'b1);
            chk("busy_fill", busy, 1'b1);
            @(posedge clk);
            #1;
            cyc++;
            if (vld) idx++;
            exp_we = vld && (idx % PPW == 0);
            chk("we", we, exp_we);
            if (exp_we) begin
                chk("waddr", waddr, nwr);
                chk("wdata", wdata, model_word(nwr));
                chk("frame_done_last", frame_done, (nwr == FW - 1));
                chk("busy_at_write", busy, (nwr != FW - 1));
                if (nwr > 0) begin
                    chk("we_spacing", ((cyc - last_we) >= PPW), 1'b1);
                end
                if (first_word_checks && nwr == 0) begin
                    chk("w0_lo_byte", wdata[7:0], 8'h00);
                    chk("w0_hi_byte", wdata[WW-1 -: 8], 8'h4F);
                end
                last_we = cyc;
                nwr++;
            end else begin
                chk("frame_done_low", frame_done, 1'b0);
            end
        end
        start = 1'b0;
        chk("frame_complete", nwr, FW);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pix_vld = 1'b0;
        pix_in  = 8'h00;
        #1;
        chk("rst_pix_rdy", pix_rdy, 1'b0);
        chk("rst_we", we, 1'b0);
        chk("rst_waddr", waddr, 9'd0);
        chk("rst_wdata", wdata, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'(i % 251);

        // pix_vld high in IDLE must not be accepted.
        pix_vld = 1'b1;
        pix_in  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_pix_rdy", pix_rdy, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_we", we, 1'b0);

        // Partial frame, then abort after 150 pixels.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_pix_rdy", pix_rdy, 1'b1);
        for (int i = 0; i < 150; i++) begin
            pix_vld = 1'b1;
            pix_in  = pix_mem[i];
            @(posedge clk);
            #1;
        end
        chk("abort_pre_wdata_hold", wdata, model_word(0));
        chk("abort_pre_we_low", we, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_pix_rdy", pix_rdy, 1'b0);
        chk("abort_we", we, 1'b0);
        chk("abort_waddr", waddr, 9'd0);
        chk("abort_wdata", wdata, '0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_frame_done", frame_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full frame at full rate. start is pulsed during FILL and must be
        // ignored. pix_vld is held high with junk data in the start cycle.
        pix_vld = 1'b1;
        pix_in  = 8'hEE;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("f1_busy", busy, 1'b1);
        chk("f1_pix_rdy", pix_rdy, 1'b1);
        run_frame(1'b0, 1'b1, 1'b1);
        chk("f1_end_pix_rdy", pix_rdy, 1'b0);
        chk("f1_end_busy", busy, 1'b0);

        // Cycle after frame_done: outputs hold, then a back-to-back start.
        pix_vld = 1'b1;
        pix_in  = 8'h5A;
        @(posedge clk);
        #1;
        chk("hold_we", we, 1'b0);
        chk("hold_frame_done", frame_done, 1'b0);
        chk("hold_waddr", waddr, 9'd511);
        chk("hold_wdata", wdata, model_word(FW - 1));
        chk("hold_pix_rdy", pix_rdy, 1'b0);

        for (int i = 0; i < NPIX; i++) pix_mem[i] = 8'($urandom);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("f2_busy", busy, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0);
        chk("f2_end_pix_rdy", pix_rdy, 1'b0);
        chk("f2_end_busy", busy, 1'b0);

        // Valid held in IDLE after the frame produces no writes.
        pix_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("post_we", we, 1'b0);
            chk("post_busy", busy, 1'b0);
        end
        pix_vld = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
